hazard_bubble_ctrl: RTL and testbench

//   Parametrised load-use / branch hazard controller with an owned ID/EX control register.

---
 rtl/hazard_bubble_ctrl_if.sv | 40 ++++
 rtl/hazard_bubble_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_bubble_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_bubble_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : hazard_bubble_ctrl_if
// Purpose  : Decoder / pipeline-control bundle for the hazard bubble controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_bubble_ctrl_if #(
  parameter int CTRL_W = 9,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [CTRL_W-1:0] ctrl_in;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rt;
  logic              branch_taken;
  logic              stall_ext;
  logic [CTRL_W-1:0] ctrl_out;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output ctrl_in, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, stall_ext,
    input  ctrl_out, pc_write, ifid_write, ifid_flush, bubble_cnt
  );

  modport slave (
    input  ctrl_in, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, stall_ext,
    output ctrl_out, pc_write, ifid_write, ifid_flush, bubble_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_bubble_ctrl.sv
//------------------------------------------------------------------------------
// Module   : hazard_bubble_ctrl
// Purpose  : Load-use / branch hazard controller owning the ID/EX control reg.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_bubble_ctrl #(
  parameter int CTRL_W    = 9,
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_bubble_ctrl_if.slave bus
);

  localparam int c_CNT_MAX = ((LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC) - 1;
  localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [CTRL_W-1:0]  r_ctrl_out;
  logic [CNT_W-1:0]   r_bubble_cnt;

  logic               w_hit;
  logic [CNT_W-1:0]   w_bubble_next;
  logic               w_pc_write;
  logic               w_ifid_write;
  logic               w_ifid_flush;

  // A zero destination is never a real dependency.
  assign w_hit = bus.ex_mem_read && (bus.ex_rt != '0) &&
                 ((bus.ex_rt == bus.id_rs) ||
                  (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  assign w_bubble_next = (r_bubble_cnt == '1) ? r_bubble_cnt
                                              : r_bubble_cnt + CNT_W'(1);

  always_comb begin
    w_pc_write   = 1'b0;
    w_ifid_write = 1'b0;
    w_ifid_flush = 1'b0;
    if (rst && !bus.stall_ext) begin
      if (bus.branch_taken) begin
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b1;
      end else begin
        case (r_state)
          ST_RUN: begin
            w_pc_write   = !w_hit;
            w_ifid_write = !w_hit;
          end
          ST_FLUSH: begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
          end
          default: begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      r_ctrl_out   <= '0;
      r_bubble_cnt <= '0;
    end else if (!bus.stall_ext) begin
      if (bus.branch_taken) begin
        r_ctrl_out   <= '0;
        r_bubble_cnt <= w_bubble_next;
        if (FLUSH_CYC > 1) begin
          r_state <= ST_FLUSH;
          r_cnt   <= c_CNT_W'(FLUSH_CYC - 1);
        end else begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_hit) begin
              r_ctrl_out   <= '0;
              r_bubble_cnt <= w_bubble_next;
              if (LOAD_LAT > 1) begin
                r_state <= ST_STALL;
                r_cnt   <= c_CNT_W'(LOAD_LAT - 1);
              end
            end else begin
              r_ctrl_out <= bus.ctrl_in;
            end
          end
          ST_STALL, ST_FLUSH: begin
            // Hazard is not re-evaluated while draining the remaining bubbles.
            r_ctrl_out   <= '0;
            r_bubble_cnt <= w_bubble_next;
            if (r_cnt == c_CNT_W'(1)) begin
              r_state <= ST_RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - c_CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.ctrl_out   = r_ctrl_out;
  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.pc_write   = w_pc_write;
  assign bus.ifid_write = w_ifid_write;
  assign bus.ifid_flush = w_ifid_flush;

endmodule

`default_nettype wire

// File: tb/tb_hazard_bubble_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_bubble_ctrl
// Purpose  : Scoreboard bench driving three differently parametrised controllers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_bubble_ctrl;

  logic       clk;
  logic       rst;
  logic [8:0] ctrl_in;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, stall_ext;

  int total = 0;
  int bad   = 0;

  hazard_bubble_ctrl_if #(.CTRL_W(9), .REG_AW(5), .CNT_W(16)) if_a ();
  hazard_bubble_ctrl_if #(.CTRL_W(9), .REG_AW(5), .CNT_W(16)) if_b ();
  hazard_bubble_ctrl_if #(.CTRL_W(9), .REG_AW(5), .CNT_W(2))  if_c ();

  hazard_bubble_ctrl #(.CTRL_W(9), .REG_AW(5), .LOAD_LAT(1), .FLUSH_CYC(1), .CNT_W(16))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  hazard_bubble_ctrl #(.CTRL_W(9), .REG_AW(5), .LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(16))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  hazard_bubble_ctrl #(.CTRL_W(9), .REG_AW(5), .LOAD_LAT(2), .FLUSH_CYC(3), .CNT_W(2))
    u_dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  assign if_a.ctrl_in = ctrl_in;  assign if_b.ctrl_in = ctrl_in;  assign if_c.ctrl_in = ctrl_in;
  assign if_a.id_rs = id_rs;      assign if_b.id_rs = id_rs;      assign if_c.id_rs = id_rs;
  assign if_a.id_rt = id_rt;      assign if_b.id_rt = id_rt;      assign if_c.id_rt = id_rt;
  assign if_a.ex_rt = ex_rt;      assign if_b.ex_rt = ex_rt;      assign if_c.ex_rt = ex_rt;
  assign if_a.id_uses_rt = id_uses_rt;
  assign if_b.id_uses_rt = id_uses_rt;
  assign if_c.id_uses_rt = id_uses_rt;
  assign if_a.ex_mem_read = ex_mem_read;
  assign if_b.ex_mem_read = ex_mem_read;
  assign if_c.ex_mem_read = ex_mem_read;
  assign if_a.branch_taken = branch_taken;
  assign if_b.branch_taken = branch_taken;
  assign if_c.branch_taken = branch_taken;
  assign if_a.stall_ext = stall_ext;
  assign if_b.stall_ext = stall_ext;
  assign if_c.stall_ext = stall_ext;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] ctrl;
    int         bub;
    logic       pc;
    logic       ifid;
    logic       fl;
  } rec_t;

  rec_t exp_q[3][$];

  // Reference model: each controller owes a number of forced bubbles.
  int         m_ll[3]  = '{1, 3, 2};
  int         m_fc[3]  = '{1, 2, 3};
  int         m_max[3] = '{65535, 65535, 3};
  int         m_pend[3];
  bit         m_pflush[3];
  int         m_bub[3];
  logic [8:0] m_ctrl[3];

  task automatic check(input string nm, input int k, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, k, $time, act, expv);
    end
  endtask

  task automatic drive(input logic r, input logic [8:0] ci, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic mr,
                       input logic [4:0] ert, input logic br, input logic se);
    bit   hit;
    bit   zero;
    rec_t e;
    @(posedge clk);
    #1;
    rst = r; ctrl_in = ci; id_rs = rs; id_rt = rt; id_uses_rt = ur;
    ex_mem_read = mr; ex_rt = ert; branch_taken = br; stall_ext = se;
    hit = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
    for (int k = 0; k < 3; k++) begin
      if (!r) begin
        m_pend[k] = 0; m_bub[k] = 0; m_ctrl[k] = '0;
      end
      e.ctrl = m_ctrl[k];
      e.bub  = m_bub[k];
      e.pc = 1'b0; e.ifid = 1'b0; e.fl = 1'b0;
      if (r && !se) begin
        zero = 1'b1;
        if (br) begin
          e.pc = 1'b1; e.ifid = 1'b1; e.fl = 1'b1;
          m_pend[k] = m_fc[k] - 1; m_pflush[k] = 1'b1;
        end else if (m_pend[k] > 0) begin
          e.pc = m_pflush[k]; e.ifid = m_pflush[k]; e.fl = m_pflush[k];
          m_pend[k]--;
        end else if (hit) begin
          m_pend[k] = m_ll[k] - 1; m_pflush[k] = 1'b0;
        end else begin
          e.pc = 1'b1; e.ifid = 1'b1;
          zero = 1'b0;
          m_ctrl[k] = ci;
        end
        if (zero) begin
          m_ctrl[k] = '0;
          if (m_bub[k] < m_max[k]) m_bub[k]++;
        end
      end
      exp_q[k].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 9'($urandom_range(1, 511)), 5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
  endtask

  task automatic load_hit(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                          input logic [4:0] ert);
    drive(1'b1, 9'($urandom_range(1, 511)), rs, rt, ur, 1'b1, ert, 1'b0, 1'b0);
  endtask

  task automatic branch();
    drive(1'b1, 9'($urandom_range(1, 511)), 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  initial begin
    logic [8:0] a_ctrl[3];
    int         a_bub[3];
    logic       a_pc[3], a_ifid[3], a_fl[3];
    rec_t       e;
    forever begin
      @(negedge clk);
      a_ctrl[0] = if_a.ctrl_out; a_bub[0] = int'(if_a.bubble_cnt);
      a_ctrl[1] = if_b.ctrl_out; a_bub[1] = int'(if_b.bubble_cnt);
      a_ctrl[2] = if_c.ctrl_out; a_bub[2] = int'(if_c.bubble_cnt);
      a_pc[0] = if_a.pc_write; a_ifid[0] = if_a.ifid_write; a_fl[0] = if_a.ifid_flush;
      a_pc[1] = if_b.pc_write; a_ifid[1] = if_b.ifid_write; a_fl[1] = if_b.ifid_flush;
      a_pc[2] = if_c.pc_write; a_ifid[2] = if_c.ifid_write; a_fl[2] = if_c.ifid_flush;
      for (int k = 0; k < 3; k++) begin
        if (exp_q[k].size() > 0) begin
          e = exp_q[k].pop_front();
          check("ctrl_out",   k, int'(a_ctrl[k]), int'(e.ctrl));
          check("bubble_cnt", k, a_bub[k],        e.bub);
          check("pc_write",   k, int'(a_pc[k]),   int'(e.pc));
          check("ifid_write", k, int'(a_ifid[k]), int'(e.ifid));
          check("ifid_flush", k, int'(a_fl[k]),   int'(e.fl));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; ctrl_in = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = '0; branch_taken = 1'b0; stall_ext = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0; m_pflush[k] = 1'b0; m_bub[k] = 0; m_ctrl[k] = '0;
    end

    // Reset held with random inputs, then first pass-through.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 9'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b1, 9'h1A5, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(2);

    // Load-use on rs.
    load_hit(5'd5, 5'd7, 1'b0, 5'd5);
    idle(4);

    // Rt hit honoured only when rt is read; r0 never hazards.
    load_hit(5'd1, 5'd6, 1'b1, 5'd6);
    idle(4);
    load_hit(5'd1, 5'd6, 1'b0, 5'd6);
    idle(2);
    load_hit(5'd0, 5'd0, 1'b1, 5'd0);
    idle(2);

    // Branch during the second stall cycle aborts the stall.
    load_hit(5'd4, 5'd9, 1'b0, 5'd4);
    branch();
    idle(4);

    // External freeze mid-stall, with hazard and branch sources toggling.
    load_hit(5'd8, 5'd2, 1'b0, 5'd8);
    idle(1);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 9'($urandom), 5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'($urandom), 1'b1);
    idle(4);

    // Saturation on the narrow counter.
    for (int i = 0; i < 5; i++) begin
      load_hit(5'd3, 5'd4, 1'b1, 5'd4);
      idle(4);
    end

    // Asynchronous reset landing inside a flush.
    branch();
    drive(1'b0, 9'h0FF, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 9'h0FF, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Randomised traffic over a small register space to provoke hazards.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 99) != 0), 9'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 6) == 0));

    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("queue_drained", k, exp_q[k].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
